// File: rtl/cam_pkg.sv
// Shared constants, widths and FSM encoding for the camera capture front end.
package cam_pkg;

  localparam int unsigned CAM_H_PIXELS      = 640;
  localparam int unsigned CAM_V_LINES       = 480;
  localparam int unsigned CAM_BYTES_PER_PIX = 2;

  localparam int unsigned HCNT_W = 10;
  localparam int unsigned PCNT_W = 11;
  localparam int unsigned FCNT_W = 3;
  // Byte counter has one extra bit so over-long lines are still seen as long.
  localparam int unsigned BCNT_W = 12;
  localparam int unsigned SKIP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ACTIVE = 2'd2
  } cam_state_t;

  // Line counter increment that sticks at the frame height.
  function automatic logic [HCNT_W-1:0] sat_inc_line(input logic [HCNT_W-1:0] cnt,
                                                     input logic [HCNT_W-1:0] lim);
    return (cnt >= lim) ? cnt : cnt + HCNT_W'(1);
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registered level with rise/fall pulses from a second delayed copy.
module cam_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic q_d;

  // Sample the input once, then keep one more delayed copy for edge compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/cam_pixel_capture.sv
// OV7670-style byte-stream capture: settle skip, RGB565 pairing, line/frame checks.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_PIXELS    = CAM_H_PIXELS,
  parameter int unsigned V_LINES     = CAM_V_LINES,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CamVsync,
  input  logic              CamHsync,
  input  logic [7:0]        CamData_in,
  output logic [15:0]       CamData_out,
  output logic [HCNT_W-1:0] CamHsync_count,
  output logic [PCNT_W-1:0] CamPix_count,
  output logic              CamData_enable,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [BCNT_W-1:0] LINE_BYTES = BCNT_W'(CAM_BYTES_PER_PIX * H_PIXELS);
  localparam logic [HCNT_W-1:0] LAST_LINE  = HCNT_W'(V_LINES);
  localparam logic [SKIP_W-1:0] SKIP_N     = SKIP_W'(SKIP_FRAMES);

  logic              vs_q, vs_rise_c, vs_fall_c;
  logic              hs_q, hs_rise_c, hs_fall_c;
  logic [7:0]        data_q;
  logic [7:0]        high_byte;
  cam_state_t        state;
  logic [SKIP_W-1:0] skip_cnt;
  logic              phase;
  logic              line_live;
  logic              ferr_clr;
  logic [BCNT_W-1:0] byte_cnt;

  logic [BCNT_W-1:0] byte_idx, byte_nxt;
  logic              phase_eff, line_open, byte_ok, line_close, line_bad;
  logic              frame_clean, frame_bad, line_abort;
  logic [HCNT_W-1:0] hcnt_inc;

  logic              unused_vsync;
  assign unused_vsync = vs_q ^ vs_fall_c;

  cam_edge_det u_vsync_det (
    .clk    (clk),
    .rst_n  (reset),
    .d      (CamVsync),
    .q      (vs_q),
    .rise_c (vs_rise_c),
    .fall_c (vs_fall_c)
  );

  cam_edge_det u_hsync_det (
    .clk    (clk),
    .rst_n  (reset),
    .d      (CamHsync),
    .q      (hs_q),
    .rise_c (hs_rise_c),
    .fall_c (hs_fall_c)
  );

  // Byte register aligned with the registered HREF level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= CamData_in;
  end

  // Per-cycle decode of the byte position, line close and frame verdict.
  always_comb begin
    phase_eff   = hs_rise_c ? 1'b0 : phase;
    byte_idx    = hs_rise_c ? '0 : byte_cnt;
    byte_nxt    = (byte_idx == '1) ? byte_idx : byte_idx + BCNT_W'(1);
    line_open   = hs_rise_c && (CamHsync_count != LAST_LINE);
    byte_ok     = hs_q && !vs_rise_c && (hs_rise_c ? line_open : line_live);
    line_close  = hs_fall_c && line_live;
    line_bad    = line_close && (byte_cnt[0] || (byte_cnt < LINE_BYTES));
    hcnt_inc    = line_close ? sat_inc_line(CamHsync_count, LAST_LINE) : CamHsync_count;
    frame_clean = (hcnt_inc == LAST_LINE) && !(line_err || line_bad);
    frame_bad   = !frame_clean && (hcnt_inc != '0);
    line_abort  = hs_q && (line_live || line_open);
  end

  // Capture FSM: later assignments deliberately override earlier ones
  // (line close before frame check, Vsync abort over byte handling).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      skip_cnt       <= '0;
      phase          <= 1'b0;
      line_live      <= 1'b0;
      ferr_clr       <= 1'b0;
      byte_cnt       <= '0;
      high_byte      <= '0;
      CamData_out    <= '0;
      CamHsync_count <= '0;
      CamPix_count   <= '0;
      CamData_enable <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      line_err       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      CamData_enable <= 1'b0;
      frame_done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (vs_rise_c) state <= (SKIP_FRAMES == 0) ? ST_ACTIVE : ST_SKIP;
        end
        ST_SKIP: begin
          if (vs_rise_c) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
            if (skip_cnt + SKIP_W'(1) == SKIP_N) state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (ferr_clr) begin
            frame_err <= 1'b0;
            ferr_clr  <= 1'b0;
          end
          if (hs_rise_c) begin
            line_live <= line_open;
            if (!line_open) frame_err <= 1'b1;
          end
          if (byte_ok) begin
            byte_cnt <= byte_nxt;
            phase    <= ~phase_eff;
            if (byte_idx >= LINE_BYTES) begin
              line_err <= 1'b1;
            end else if (!phase_eff) begin
              high_byte <= data_q;
            end else begin
              CamData_out    <= {high_byte, data_q};
              CamPix_count   <= PCNT_W'(byte_idx);
              CamData_enable <= 1'b1;
            end
          end
          if (line_close) begin
            line_live      <= 1'b0;
            CamHsync_count <= hcnt_inc;
            if (line_bad) line_err <= 1'b1;
          end
          if (vs_rise_c) begin
            line_live      <= 1'b0;
            CamHsync_count <= '0;
            line_err       <= 1'b0;
            frame_err      <= frame_bad || line_abort;
            ferr_clr       <= frame_bad || line_abort;
            if (frame_clean) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + FCNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture with a reduced frame size.
module tb_cam_pixel_capture;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int SK = 2;
  localparam int LB = 2 * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        CamVsync = 1'b0;
  logic        CamHsync = 1'b0;
  logic [7:0]  CamData_in = 8'h00;
  logic [15:0] CamData_out;
  logic [9:0]  CamHsync_count;
  logic [10:0] CamPix_count;
  logic        CamData_enable;
  logic        frame_done;
  logic [2:0]  frame_count;
  logic        line_err;
  logic        frame_err;

  typedef struct packed {
    logic [15:0] data;
    logic [10:0] pix;
    logic [9:0]  line;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_strobe = 0;
  int          n_done = 0;
  int          n_ferr = 0;
  int          cyc = 0;
  int          drv_cyc = 0;
  int          first_cyc = 0;
  logic [15:0] first_data = 16'h0000;
  bit          want_first = 1'b0;
  int          base;

  cam_pixel_capture #(
    .H_PIXELS    (H),
    .V_LINES     (V),
    .SKIP_FRAMES (SK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .CamVsync       (CamVsync),
    .CamHsync       (CamHsync),
    .CamData_in     (CamData_in),
    .CamData_out    (CamData_out),
    .CamHsync_count (CamHsync_count),
    .CamPix_count   (CamPix_count),
    .CamData_enable (CamData_enable),
    .frame_done     (frame_done),
    .frame_count    (frame_count),
    .line_err       (line_err),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor on the falling edge: pulse counters and scoreboard pops.
  initial forever begin
    @(negedge clk);
    if (frame_done) n_done++;
    if (frame_err) n_ferr++;
    if (CamData_enable) begin
      n_strobe++;
      if (want_first) begin
        first_cyc  = cyc;
        first_data = CamData_out;
        want_first = 1'b0;
      end
      if (sb.size() == 0) begin
        chk("spurious_strobe", 32'(CamData_enable), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pix_data", 32'(CamData_out), 32'(mon_e.data));
        chk("pix_count", 32'(CamPix_count), 32'(mon_e.pix));
        chk("pix_line", 32'(CamHsync_count), 32'(mon_e.line));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic vs, input logic hs, input logic [7:0] d);
    @(negedge clk);
    CamVsync   = vs;
    CamHsync   = hs;
    CamData_in = d;
  endtask

  // One HREF burst of n bytes followed by a blanking gap.
  task automatic send_line(input int n, input bit cap, input int line_idx, input bit fixed);
    logic [7:0] d;
    logic [7:0] hi;
    hi = 8'h00;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      if (fixed && i == 0) d = 8'hF8;
      if (fixed && i == 1) d = 8'h1F;
      drive(1'b0, 1'b1, d);
      if (fixed && i == 1) drv_cyc = cyc;
      if (i % 2 == 0) hi = d;
      else if (cap && i < LB) sb.push_back('{data: {hi, d}, pix: 11'(i), line: 10'(line_idx)});
    end
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_edge();
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int nl, input bit cap);
    for (int l = 0; l < nl; l++) send_line(LB, cap, l, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] hi;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("rst_enable", 32'(CamData_enable), 32'd0);
    chk("rst_data", 32'(CamData_out), 32'd0);
    chk("rst_hcnt", 32'(CamHsync_count), 32'd0);
    chk("rst_fcnt", 32'(frame_count), 32'd0);
    chk("rst_flags", 32'({line_err, frame_err, frame_done}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // Settle frames: nothing captured
    vsync_edge();
    send_frame(V, 1'b0);
    vsync_edge();
    send_frame(V, 1'b0);
    chk("skip_no_strobe", 32'(n_strobe), 32'd0);
    chk("skip_no_done", 32'(n_done), 32'd0);

    // Frame A: first captured frame, with a known first pixel
    vsync_edge();
    want_first = 1'b1;
    send_line(LB, 1'b1, 0, 1'b1);
    for (int l = 1; l < V; l++) send_line(LB, 1'b1, l, 1'b0);
    chk("pair_latency", 32'(first_cyc - drv_cyc), 32'd2);
    chk("pair_data", 32'(first_data), 32'hF81F);
    chk("hcnt_full", 32'(CamHsync_count), 32'(V));
    vsync_edge();
    chk("frameA_strobes", 32'(n_strobe), 32'(V * H));
    chk("frameA_done", 32'(n_done), 32'd1);
    chk("frameA_fcnt", 32'(frame_count), 32'd1);
    chk("frameA_hcnt_clr", 32'(CamHsync_count), 32'd0);

    // Frame B: extra line after the last one is ignored
    send_frame(V, 1'b1);
    send_line(LB, 1'b0, V, 1'b0);
    chk("hcnt_sat", 32'(CamHsync_count), 32'(V));
    chk("ferr_extra_line", 32'(frame_err), 32'd1);
    vsync_edge();
    chk("frameB_done", 32'(n_done), 32'd2);
    chk("frameB_fcnt", 32'(frame_count), 32'd2);
    chk("frameB_ferr_clr", 32'(frame_err), 32'd0);

    // Frame C: short and long lines
    n_ferr = 0;
    base = n_strobe;
    send_line(LB - 1, 1'b1, 0, 1'b0);
    chk("short_strobes", 32'(n_strobe - base), 32'(H - 1));
    chk("short_lerr", 32'(line_err), 32'd1);
    base = n_strobe;
    send_line(LB + 2, 1'b1, 1, 1'b0);
    chk("long_strobes", 32'(n_strobe - base), 32'(H));
    chk("long_lerr", 32'(line_err), 32'd1);
    for (int l = 2; l < V; l++) send_line(LB, 1'b1, l, 1'b0);
    vsync_edge();
    chk("frameC_no_done", 32'(n_done), 32'd2);
    chk("frameC_ferr_pulse", 32'(n_ferr), 32'd1);
    chk("frameC_fcnt", 32'(frame_count), 32'd2);
    chk("frameC_lerr_clr", 32'(line_err), 32'd0);

    // Frame D: Vsync rises in the middle of line 2
    n_ferr = 0;
    send_line(LB, 1'b1, 0, 1'b0);
    send_line(LB, 1'b1, 1, 1'b0);
    base = n_strobe;
    hi = 8'h00;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      drive(1'b0, 1'b1, d);
      if (i % 2 == 0) hi = d;
      else sb.push_back('{data: {hi, d}, pix: 11'(i), line: 10'd2});
    end
    repeat (3) drive(1'b1, 1'b1, 8'hA5);
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    chk("abort_strobes", 32'(n_strobe - base), 32'd2);
    chk("abort_ferr_pulse", 32'(n_ferr), 32'd1);
    chk("abort_hcnt", 32'(CamHsync_count), 32'd0);
    chk("abort_fcnt", 32'(frame_count), 32'd2);
    chk("abort_no_done", 32'(n_done), 32'd2);

    // Frame E: reset after three lines
    send_frame(3, 1'b1);
    chk("preRst_hcnt", 32'(CamHsync_count), 32'd3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midRst_hcnt", 32'(CamHsync_count), 32'd0);
    chk("midRst_fcnt", 32'(frame_count), 32'd0);
    chk("midRst_data", 32'(CamData_out), 32'd0);
    chk("midRst_pcnt", 32'(CamPix_count), 32'd0);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Capture resumes only after SKIP_FRAMES+1 Vsync edges
    base = n_strobe;
    send_line(LB, 1'b0, 0, 1'b0);
    send_line(LB, 1'b0, 1, 1'b0);
    vsync_edge();
    send_line(LB, 1'b0, 0, 1'b0);
    vsync_edge();
    send_line(LB, 1'b0, 0, 1'b0);
    chk("postRst_skip", 32'(n_strobe - base), 32'd0);
    vsync_edge();
    send_line(LB, 1'b1, 0, 1'b0);
    chk("resume_strobes", 32'(n_strobe - base), 32'(H));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Capture front end for the OV7670-style sensor, clocked by the camera pixel clock.
- Samples the 8-bit byte stream with HREF/VSYNC framing and assembles RGB565 pixels from byte pairs.
- Produces the line counter, byte counter and pixel strobe that the Avalon-MM camera controller uses to fill its line buffers and drive its filters.
- Adds settle-frame skipping, frame numbering and framing-error detection.

Parameters:
- H_PIXELS, 640, active pixels per line; the line carries 2*H_PIXELS bytes.
- V_LINES, 480, active lines per frame.
- SKIP_FRAMES, 2, number of whole frames discarded after reset (sensor settle).

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- CamVsync  in  1  frame sync; a rising edge marks a frame boundary.
- CamHsync  in  1  HREF; high while line bytes are valid.
- CamData_in  in  8  sensor byte.
- CamData_out  out  16  assembled RGB565 pixel: first byte is [15:8], second byte is [7:0].
- CamHsync_count  out  10  index of the current line within the frame.
- CamPix_count  out  11  byte index of the completing (second) byte, so CamPix_count>>1 is the pixel index.
- CamData_enable  out  1  one-cycle strobe marking CamData_out valid.
- frame_done  out  1  one-cycle pulse at the end of a clean frame.
- frame_count  out  3  number of completed frames, modulo 8.
- line_err  out  1  sticky line error, cleared at each Vsync rising edge.
- frame_err  out  1  sticky frame error, cleared at each Vsync rising edge.

Behaviour:
- Input stage: CamVsync, CamHsync and CamData_in are registered once. Edge detection compares the registered value with a second delayed copy.
- Reset values: all outputs 0; state IDLE; skip counter 0; byte phase 0.
- FSM states: IDLE, SKIP, ACTIVE.
  - IDLE -> SKIP on the first Vsync rising edge. If SKIP_FRAMES==0, go directly to ACTIVE instead.
  - SKIP: each Vsync rising edge increments the skip counter. On the edge where the counter reaches SKIP_FRAMES, go to ACTIVE. No strobes, flags or counter updates occur in SKIP.
  - ACTIVE: remains in ACTIVE until reset.
- Line capture (ACTIVE only):
  - An HREF rising edge clears the byte counter and the phase.
  - Each registered byte while HREF is high toggles the phase.
  - Phase 0 stores the byte as the high half.
  - Phase 1 outputs {high, byte} on CamData_out, sets CamPix_count to the byte index (odd), and pulses CamData_enable.
- Latency: the second byte of a pair present at the inputs at edge N gives CamData_enable high for the cycle after edge N+1. CamData_out and CamPix_count are stable during that strobe and hold until the next strobe.
- Line end: on an HREF falling edge, CamHsync_count increments, saturating at V_LINES. The counter therefore reads V_LINES after the last line.
- Bytes beyond 2*H_PIXELS in a line: no strobe, and line_err is set.
- Line closes with an odd byte count or a byte count below 2*H_PIXELS: the trailing byte is dropped and line_err is set.
- HREF rising while CamHsync_count==V_LINES: the line is ignored (no strobes) and frame_err is set.
- Vsync rising edge in ACTIVE:
  - If CamHsync_count==V_LINES and line_err==0: pulse frame_done and increment frame_count (7 wraps to 0).
  - Otherwise, if any lines were received, set frame_err for one cycle, then clear it together with line_err.
  - Afterwards CamHsync_count=0. Both sticky flags are then cleared, except that a frame_err raised by this same edge wins for that cycle.
- Vsync rising while HREF is high: the partial line is aborted, no further strobes occur for it, and frame_err is set.
- Simultaneous HREF falling edge and Vsync rising edge: the line increment is applied first, then the frame check.
- Reset asserted mid-frame: all state is cleared immediately. The block must pass IDLE and SKIP again before emitting strobes.

Decomposition:
- Package cam_pkg holds:
  - constants CAM_H_PIXELS=640, CAM_V_LINES=480 and CAM_BYTES_PER_PIX=2;
  - the FSM state encoding IDLE/SKIP/ACTIVE;
  - widths HCNT_W=10, PCNT_W=11, FCNT_W=3.
- One sub-module, cam_edge_det: a registered input with rise and fall pulse outputs, instantiated for CamVsync and CamHsync.

Test Plan:
- Settle skip: reset, then 3 clean frames with SKIP_FRAMES=2 -> no strobes in frames 1-2; frame 3 gives 307200 CamData_enable pulses, frame_done=1 once, frame_count=1.
- Pixel pairing: bytes 0xF8,0x1F at the start of line 0 -> CamData_out=0xF81F, CamPix_count=1, CamHsync_count=0; the strobe occurs 2 cycles after the second byte.
- Line counting: full 480-line frame -> CamHsync_count reaches 480 and saturates there; the next Vsync edge resets it to 0 and frame_count increments.
- Short and long lines: a line of 1279 bytes -> 639 strobes and line_err=1; a line of 1282 bytes -> 640 strobes and line_err=1; at the next Vsync there is no frame_done and frame_err pulses.
- Vsync mid-line: Vsync rising after 300 bytes of line 10 -> strobes stop, frame_err=1, CamHsync_count=0, frame_count unchanged.
- Reset mid-frame: reset at line 200 -> outputs 0 immediately; with no further Vsync there are no strobes; capture resumes only after SKIP_FRAMES+1 Vsync edges.
